// File: rtl/guess_solver_pkg.sv
// guess_solver_pkg: FSM state encoding and width helpers shared by the guess solver.
package guess_solver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BASE_ISSUE,
        BASE_WAIT,
        PROBE_ISSUE,
        PROBE_WAIT,
        FINAL_ISSUE,
        FINAL_WAIT,
        DONE
    } state_t;

    localparam int N_DEF = 6;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int gcnt_w(input int n);
        return $clog2(n + 3);
    endfunction

endpackage

// File: rtl/guess_solver.sv
// guess_solver: recovers an N-bit hidden target from match-count feedback using
// one all-zero baseline guess, N one-hot probes and a final confirming guess.
module guess_solver
    import guess_solver_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int CW = $clog2(N + 1),
    localparam int GW = gcnt_w(N)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Start,
    output logic [N-1:0]  Guess_num,
    output logic          Guess_valid,
    input  logic [CW-1:0] Feedback_cnt,
    input  logic          Feedback_valid,
    output logic [N-1:0]  Solved_num,
    output logic          Done,
    output logic          Error,
    output logic [GW-1:0] Guess_count
);

    state_t        r_state;
    logic [N-1:0]  r_guess;
    logic          r_gvalid;
    logic [N-1:0]  r_solved;
    logic          r_done;
    logic          r_err;
    logic [GW-1:0] r_gcnt;
    logic [CW-1:0] r_c0;
    logic [CW-1:0] r_idx;
    logic          w_fb;
    logic [GW-1:0] w_gcnt_nxt;

    // Feedback landing in the same cycle as the guess pulse cannot belong to it.
    assign w_fb       = Feedback_valid && !r_gvalid;
    assign w_gcnt_nxt = (r_gcnt == '1) ? r_gcnt : r_gcnt + 1'b1;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_guess  <= '0;
            r_gvalid <= 1'b0;
            r_solved <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_gcnt   <= '0;
            r_c0     <= '0;
            r_idx    <= '0;
        end else begin
            r_gvalid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (Start) begin
                        r_state <= BASE_ISSUE;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_gcnt  <= '0;
                        r_idx   <= '0;
                    end
                end
                BASE_ISSUE: begin
                    r_guess  <= '0;
                    r_gvalid <= 1'b1;
                    r_gcnt   <= w_gcnt_nxt;
                    r_state  <= BASE_WAIT;
                end
                BASE_WAIT: begin
                    if (w_fb) begin
                        r_c0    <= Feedback_cnt;
                        r_state <= PROBE_ISSUE;
                    end
                end
                PROBE_ISSUE: begin
                    r_guess  <= N'(1) << r_idx;
                    r_gvalid <= 1'b1;
                    r_gcnt   <= w_gcnt_nxt;
                    r_state  <= PROBE_WAIT;
                end
                PROBE_WAIT: begin
                    if (w_fb) begin
                        r_solved[r_idx] <= Feedback_cnt > r_c0;
                        r_idx           <= (r_idx == CW'(N - 1)) ? r_idx : r_idx + 1'b1;
                        r_state         <= (r_idx == CW'(N - 1)) ? FINAL_ISSUE : PROBE_ISSUE;
                    end
                end
                FINAL_ISSUE: begin
                    r_guess  <= r_solved;
                    r_gvalid <= 1'b1;
                    r_gcnt   <= w_gcnt_nxt;
                    r_state  <= FINAL_WAIT;
                end
                FINAL_WAIT: begin
                    if (w_fb) begin
                        r_err   <= Feedback_cnt != CW'(N);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Guess_num   = r_guess;
    assign Guess_valid = r_gvalid;
    assign Solved_num  = r_solved;
    assign Done        = r_done;
    assign Error       = r_err;
    assign Guess_count = r_gcnt;

endmodule

// File: tb/tb_guess_solver.sv
// tb_guess_solver: directed scoreboard bench; a responder answers each guess
// with the match count against a chosen target, a monitor pops expected guesses.
module tb_guess_solver;
    import guess_solver_pkg::*;

    localparam int N  = 6;
    localparam int CW = $clog2(N + 1);
    localparam int GW = $clog2(N + 3);

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [N-1:0]  Guess_num;
    logic          Guess_valid;
    logic [CW-1:0] Feedback_cnt;
    logic          Feedback_valid;
    logic [N-1:0]  Solved_num;
    logic          Done;
    logic          Error;
    logic [GW-1:0] Guess_count;

    logic [N-1:0]  tgt = '0;
    bit            force_err = 0;
    bit            rand_lat = 0;
    bit            noise_en = 0;
    int            rsp_n = 0;
    logic          rsp_fv = 1'b0;
    logic [CW-1:0] rsp_cnt = '0;
    logic          noise_fv = 1'b0;
    logic [CW-1:0] noise_cnt = '0;
    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  sb[$];

    assign Feedback_valid = rsp_fv | noise_fv;
    assign Feedback_cnt   = noise_fv ? noise_cnt : rsp_cnt;

    guess_solver #(.N(N)) dut (
        .clk(clk), .Reset(Reset), .Start(Start),
        .Guess_num(Guess_num), .Guess_valid(Guess_valid),
        .Feedback_cnt(Feedback_cnt), .Feedback_valid(Feedback_valid),
        .Solved_num(Solved_num), .Done(Done), .Error(Error),
        .Guess_count(Guess_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder: match count of the guess against tgt, after 1..10 cycles.
    initial begin
        logic [N-1:0]  g;
        logic [CW-1:0] f;
        int            lat;
        forever begin
            @(negedge clk);
            if (Guess_valid) begin
                g = Guess_num;
                rsp_n++;
                f = CW'(N - $countones(g ^ tgt));
                if (force_err && rsp_n == N + 2) f = CW'(5);
                lat = rand_lat ? int'($urandom_range(1, 10)) : 1;
                repeat (lat) @(negedge clk);
                rsp_cnt = f;
                rsp_fv  = 1'b1;
                @(negedge clk);
                rsp_fv  = 1'b0;
            end
        end
    end

    // Spurious feedback while the solver is idle or issuing a guess.
    initial begin
        forever begin
            @(negedge clk);
            noise_fv  = noise_en && (dut.r_state inside {IDLE, BASE_ISSUE, PROBE_ISSUE, FINAL_ISSUE});
            noise_cnt = CW'($urandom_range(0, N));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (Guess_valid) begin
                chk("guess_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("guess", 32'(Guess_num), 32'(sb.pop_front()));
            end
        end
    end

    task automatic push_model(input logic [N-1:0] t);
        sb.push_back('0);
        for (int i = 0; i < N; i++) sb.push_back(N'(1) << i);
        sb.push_back(t);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic run_solve(input logic [N-1:0] t, input bit push, input bit err,
                             input bit mid_start, input string tag);
        int k;
        tgt       = t;
        force_err = err;
        rsp_n     = 0;
        if (push) push_model(t);
        pulse_start();
        if (mid_start) begin
            repeat (10) @(negedge clk);
            Start = 1'b1;
            @(negedge clk);
            Start = 1'b0;
        end
        for (k = 0; k < 3000 && !Done; k++) @(negedge clk);
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_solved"}, 32'(Solved_num), 32'(t));
        chk({tag, "_error"}, 32'(Error), 32'(err));
        chk({tag, "_gcount"}, 32'(Guess_count), 32'(N + 2));
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        #12;
        chk("rst_guess", 32'(Guess_num), 0);
        chk("rst_valid", 32'(Guess_valid), 0);
        chk("rst_solved", 32'(Solved_num), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_error", 32'(Error), 0);
        chk("rst_gcount", 32'(Guess_count), 0);
        @(negedge clk);
        Reset = 1'b0;
        noise_en = 1;
        repeat (10) @(negedge clk);
        noise_en = 0;
        chk("idle_no_guess", 32'(Guess_count), 0);

        foreach (sb[i]) sb.delete(i);
        sb.push_back(6'b000000); sb.push_back(6'b000001); sb.push_back(6'b000010);
        sb.push_back(6'b000100); sb.push_back(6'b001000); sb.push_back(6'b010000);
        sb.push_back(6'b100000); sb.push_back(6'b010101);
        run_solve(6'b010101, 0, 0, 0, "ex");

        run_solve(6'b000000, 1, 0, 0, "zero");
        run_solve(6'b111111, 1, 0, 0, "ones");
        run_solve(6'b010101, 1, 1, 0, "err");

        noise_en = 1;
        run_solve(6'b101100, 1, 0, 1, "noise");
        noise_en = 0;

        tgt = 6'b010101;
        force_err = 0;
        rsp_n = 0;
        push_model(tgt);
        pulse_start();
        for (k = 0; k < 500 && !(dut.r_state == PROBE_WAIT && dut.r_idx == 3); k++) @(negedge clk);
        chk("reach_probe3", 32'(k < 500), 1);
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_guess", 32'(Guess_num), 0);
        chk("mid_rst_valid", 32'(Guess_valid), 0);
        chk("mid_rst_solved", 32'(Solved_num), 0);
        chk("mid_rst_done", 32'(Done), 0);
        chk("mid_rst_error", 32'(Error), 0);
        chk("mid_rst_gcount", 32'(Guess_count), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("post_rst_idle", 32'(Guess_count), 0);
        run_solve(6'b110010, 1, 0, 0, "restart");

        rand_lat = 1;
        run_solve(6'b010101, 1, 0, 0, "rlat_a");
        run_solve(6'b100111, 1, 0, 0, "rlat_b");
        run_solve(6'(32'($urandom_range(0, 63))), 1, 0, 0, "rlat_c");
        rand_lat = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
